// File: rtl/nrisc_ula_exec_stage.sv
// Execute stage around NRISC_ULA: issue register (S1) feeds the ALU, result register (S2)
// feeds writeback. Operand bypass from both stages; owns the architectural flag register.
module nrisc_ula_exec_stage #(
  parameter int TAM = 16,
  parameter int RW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic           in_incdec,
  input  logic           in_cmp2,
  input  logic [RW-1:0]  in_ra,
  input  logic [RW-1:0]  in_rb,
  input  logic [TAM-1:0] in_a,
  input  logic [TAM-1:0] in_b,
  input  logic [TAM-1:0] in_imm,
  input  logic           in_use_imm,
  input  logic [RW-1:0]  in_rd,
  input  logic           in_setflags,
  output logic [TAM-1:0] ULA_A,
  output logic [TAM-1:0] ULA_B,
  output logic [3:0]     ULA_ctrl,
  output logic           incdec,
  output logic           cmp2,
  input  logic [TAM-1:0] ULA_OUT,
  input  logic [2:0]     ULA_flags,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [RW-1:0]  wb_rd,
  output logic [TAM-1:0] wb_data,
  output logic           wb_we,
  output logic [2:0]     flags_q,
  output logic           illegal_op
);

  function automatic logic op_legal(input logic [3:0] op);
    return (op[3] == 1'b0) || (op == 4'b1101) || (op == 4'b1110);
  endfunction

  // S1: issue register
  logic           s1_v;
  logic [3:0]     s1_op;
  logic           s1_incdec;
  logic           s1_cmp2;
  logic [TAM-1:0] s1_a;
  logic [TAM-1:0] s1_b;
  logic [RW-1:0]  s1_rd;
  logic           s1_setflags;
  logic           s1_legal;

  // S2: result register
  logic           s2_v;
  logic [RW-1:0]  s2_rd;
  logic [TAM-1:0] s2_data;
  logic           s2_we;

  logic           adv2;
  logic           accept;
  logic [TAM-1:0] opa;
  logic [TAM-1:0] opb;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid stays high with a stable payload until that edge, ready may change freely.
  assign adv2     = s1_v & (~s2_v | wb_ready);
  assign in_ready = ~rst & (~s1_v | adv2);
  assign accept   = in_valid & in_ready;

  // The younger in-flight result (S1, still on the ALU) wins over S2.
  always_comb begin
    opa = in_a;
    if (s1_v && s1_legal && (in_ra == s1_rd)) begin
      opa = ULA_OUT;
    end else if (s2_v && s2_we && (in_ra == s2_rd)) begin
      opa = s2_data;
    end
    opb = in_b;
    if (in_use_imm) begin
      opb = in_imm;
    end else if (s1_v && s1_legal && (in_rb == s1_rd)) begin
      opb = ULA_OUT;
    end else if (s2_v && s2_we && (in_rb == s2_rd)) begin
      opb = s2_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v        <= 1'b0;
      s1_op       <= '0;
      s1_incdec   <= 1'b0;
      s1_cmp2     <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_rd       <= '0;
      s1_setflags <= 1'b0;
      s1_legal    <= 1'b0;
    end else if (accept) begin
      s1_v        <= 1'b1;
      s1_op       <= in_op;
      s1_incdec   <= in_incdec;
      s1_cmp2     <= in_cmp2;
      s1_a        <= opa;
      s1_b        <= opb;
      s1_rd       <= in_rd;
      s1_setflags <= in_setflags;
      s1_legal    <= op_legal(in_op);
    end else if (adv2) begin
      s1_v <= 1'b0;
    end
  end

  // Illegal ops still travel through S2 with we=0 so writeback order is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v       <= 1'b0;
      s2_rd      <= '0;
      s2_data    <= '0;
      s2_we      <= 1'b0;
      flags_q    <= '0;
      illegal_op <= 1'b0;
    end else if (adv2) begin
      s2_v       <= 1'b1;
      s2_rd      <= s1_rd;
      s2_data    <= ULA_OUT;
      s2_we      <= s1_legal;
      illegal_op <= ~s1_legal;
      if (s1_setflags && s1_legal) begin
        flags_q <= ULA_flags;
      end
    end else begin
      illegal_op <= 1'b0;
      if (wb_ready && s2_v) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign ULA_A    = s1_v ? s1_a      : '0;
  assign ULA_B    = s1_v ? s1_b      : '0;
  assign ULA_ctrl = s1_v ? s1_op     : 4'b0000;
  assign incdec   = s1_v ? s1_incdec : 1'b0;
  assign cmp2     = s1_v ? s1_cmp2   : 1'b0;

  assign wb_valid = s2_v;
  assign wb_rd    = s2_rd;
  assign wb_data  = s2_data;
  assign wb_we    = s2_we;

endmodule

// File: tb/tb_nrisc_ula_exec_stage.sv
// Bench for nrisc_ula_exec_stage: behavioural ALU on the ALU ports, program-order register/flag
// model for expected results, scoreboard monitor on the writeback port.
module tb_nrisc_ula_exec_stage;
  localparam int TAM = 16;
  localparam int RW  = 4;
  localparam int EW  = RW + TAM + 1 + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic           in_incdec;
  logic           in_cmp2;
  logic [RW-1:0]  in_ra;
  logic [RW-1:0]  in_rb;
  logic [TAM-1:0] in_a;
  logic [TAM-1:0] in_b;
  logic [TAM-1:0] in_imm;
  logic           in_use_imm;
  logic [RW-1:0]  in_rd;
  logic           in_setflags;
  logic [TAM-1:0] ula_a;
  logic [TAM-1:0] ula_b;
  logic [3:0]     ula_ctrl;
  logic           ula_incdec;
  logic           ula_cmp2;
  logic [TAM-1:0] ula_out;
  logic [2:0]     ula_flags;
  logic           wb_valid;
  logic           wb_ready;
  logic [RW-1:0]  wb_rd;
  logic [TAM-1:0] wb_data;
  logic           wb_we;
  logic [2:0]     flags_q;
  logic           illegal_op;

  nrisc_ula_exec_stage #(.TAM(TAM), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_incdec(in_incdec), .in_cmp2(in_cmp2), .in_ra(in_ra), .in_rb(in_rb),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .in_setflags(in_setflags), .ULA_A(ula_a), .ULA_B(ula_b), .ULA_ctrl(ula_ctrl),
    .incdec(ula_incdec), .cmp2(ula_cmp2), .ULA_OUT(ula_out), .ULA_flags(ula_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_we(wb_we), .flags_q(flags_q), .illegal_op(illegal_op)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural ALU: {z, n, c, result} ----------------
  function automatic logic [18:0] alu(input logic [3:0] op, input logic id, input logic c2,
                                      input logic [15:0] a, input logic [15:0] b);
    int s;
    logic [15:0] r;
    logic z, n, c;
    s = 0; r = '0; c = 1'b0;
    case (op)
      4'd0:  begin s = int'(a) + int'(b); r = s[15:0]; c = (s > 65535); end
      4'd1:  begin s = int'(a) - int'(b); r = s[15:0]; c = (s < 0); end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~a;
      4'd6:  begin r = a << 1; c = a[15]; end
      4'd7:  begin r = a >> 1; c = a[0]; end
      4'd13: r = id ? a + 16'd1 : a - 16'd1;
      default: r = '0;
    endcase
    z = (r == 16'd0);
    n = r[15];
    if (op == 4'd14) begin
      z = (a == b);
      n = c2 ? ($signed(a) < $signed(b)) : (a < b);
      c = (a > b);
    end
    return {z, n, c, r};
  endfunction

  always_comb {ula_flags, ula_out} = alu(ula_ctrl, ula_incdec, ula_cmp2, ula_a, ula_b);

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd7) || (op == 4'd13) || (op == 4'd14);
  endfunction

  // ---------------- model state and scoreboard ----------------
  logic [TAM-1:0] rf[16];    // register file as written back
  logic [TAM-1:0] arch[16];  // register file in program order (as of last accepted op)
  logic [2:0]     mflags;
  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_fail = 0;
  int             n_acc = 0;
  int             wb_mode = 0;  // 0 ready, 1 random, 2 held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reg(input int idx, input logic [TAM-1:0] v);
    rf[idx]   = v;
    arch[idx] = v;
  endtask

  // ---------------- driver ----------------
  initial begin
    wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (wb_mode)
        0:       wb_ready = 1'b1;
        1:       wb_ready = 1'($urandom_range(0, 1));
        default: wb_ready = 1'b0;
      endcase
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic id, input logic c2,
                       input logic [RW-1:0] ra, input logic [RW-1:0] rb,
                       input logic [TAM-1:0] imm, input logic use_imm,
                       input logic [RW-1:0] rd, input logic sf);
    int waited;
    logic [15:0] a, b;
    logic [18:0] res;
    in_valid = 1'b1; in_op = op; in_incdec = id; in_cmp2 = c2;
    in_ra = ra; in_rb = rb; in_a = rf[ra]; in_b = rf[rb];
    in_imm = imm; in_use_imm = use_imm; in_rd = rd; in_setflags = sf;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'(waited), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    a = arch[ra];
    b = use_imm ? imm : arch[rb];
    res = alu(op, id, c2, a, b);
    if (is_legal(op)) begin
      arch[rd] = res[15:0];
      if (sf) mflags = res[18:16];
    end
    exp_q.push_back({rd, res[15:0], is_legal(op), mflags});
    n_acc++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || wb_valid) && t < 300) begin
      step(1);
      t++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic prev_valid, prev_fire, new_entry, fire;
    logic [TAM-1:0] held;
    logic [EW-1:0] e;
    prev_valid = 1'b0; prev_fire = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
      end else begin
        new_entry = wb_valid && (!prev_valid || prev_fire);
        if (new_entry) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(wb_data), 32'hDEAD_0000);
          end else begin
            e = exp_q.pop_front();
            check("wb_rd", 32'(wb_rd), 32'(e[EW-1 -: RW]));
            check("wb_data", 32'(wb_data), 32'(e[TAM+3 : 4]));
            check("wb_we", 32'(wb_we), 32'(e[3]));
            check("flags_q", 32'(flags_q), 32'(e[2:0]));
            check("illegal_op", 32'(illegal_op), 32'(!e[3]));
          end
          held = wb_data;
        end else begin
          check("illegal_idle", 32'(illegal_op), 32'd0);
          if (wb_valid) check("wb_data_hold", 32'(wb_data), 32'(held));
        end
        fire = wb_valid && wb_ready;
        if (fire && wb_we) rf[wb_rd] = wb_data;
        prev_valid = wb_valid;
        prev_fire  = fire;
      end
    end
  end

  // ---------------- main sequence ----------------
  logic [3:0] legal_ops[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd13, 4'd14};
  logic [3:0] bad_ops[6]    = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};
  logic       stall_done;

  initial begin
    int acc0;
    for (int i = 0; i < 16; i++) set_reg(i, 16'($urandom));
    mflags = 3'b000;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_incdec = 1'b0; in_cmp2 = 1'b0;
    in_ra = '0; in_rb = '0; in_a = '0; in_b = '0; in_imm = '0; in_use_imm = 1'b0;
    in_rd = '0; in_setflags = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD 3+4 -> r2, result visible one edge after acceptance
    set_reg(8, 16'h0003); set_reg(9, 16'h0004);
    issue(4'd0, 1'b0, 1'b0, 4'd8, 4'd9, 16'h0, 1'b0, 4'd2, 1'b0);
    check("lat_before", 32'(wb_valid), 32'd0);
    step(1);
    check("lat_after", 32'(wb_valid), 32'd1);
    check("add_data", 32'(wb_data), 32'h0007);
    wait_idle();

    // SUB 0x10-1 -> r1, then AND r1 & r5 with stale r1=0xFFFF: S1 bypass
    set_reg(1, 16'hFFFF); set_reg(3, 16'h0010); set_reg(4, 16'h0001); set_reg(5, 16'h00F0);
    issue(4'd1, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd1, 1'b0);
    issue(4'd2, 1'b0, 1'b0, 4'd1, 4'd5, 16'h0, 1'b0, 4'd6, 1'b0);
    wait_idle();
    check("s1_bypass_rf", 32'(rf[6]), 32'h0000);
    // same with a bubble: S2 bypass
    set_reg(1, 16'hFFFF); set_reg(6, 16'h1234);
    issue(4'd1, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd1, 1'b0);
    step(1);
    issue(4'd2, 1'b0, 1'b0, 4'd1, 4'd5, 16'h0, 1'b0, 4'd6, 1'b0);
    wait_idle();
    check("s2_bypass_rf", 32'(rf[6]), 32'h0000);

    // writeback stalled: two ops held, third waits
    wb_mode = 2;
    step(1);
    acc0 = n_acc;
    stall_done = 1'b0;
    fork
      begin
        issue(4'd0, 1'b0, 1'b0, 4'd8, 4'd9, 16'h0, 1'b0, 4'd10, 1'b0);
        issue(4'd3, 1'b0, 1'b0, 4'd3, 4'd5, 16'h0, 1'b0, 4'd11, 1'b0);
        issue(4'd4, 1'b0, 1'b0, 4'd10, 4'd11, 16'h0, 1'b0, 4'd12, 1'b0);
        stall_done = 1'b1;
      end
    join_none
    step(8);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_accepts", 32'(n_acc - acc0), 32'd2);
    wb_mode = 0;
    for (int t = 0; t < 50 && !stall_done; t++) step(1);
    check("stall_release", 32'(stall_done), 32'd1);
    wait_idle();

    // illegal op with setflags, then a legal flag-setting op
    set_reg(7, 16'h0000);
    issue(4'd1, 1'b0, 1'b0, 4'd7, 4'd4, 16'h0, 1'b0, 4'd13, 1'b1);
    issue(4'd8, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd14, 1'b1);
    issue(4'd0, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd14, 1'b1);
    wait_idle();

    // immediate wins over a matching in-flight rb
    set_reg(0, 16'hFFFF);
    issue(4'd3, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd7, 1'b0);
    issue(4'd4, 1'b0, 1'b0, 4'd0, 4'd7, 16'h8000, 1'b1, 4'd15, 1'b0);
    wait_idle();
    check("imm_xor_rf", 32'(rf[15]), 32'h7FFF);

    // randomized traffic with random backpressure
    wb_mode = 1;
    for (int k = 0; k < 400; k++) begin
      logic [3:0] op;
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
      op = ($urandom_range(0, 9) == 0) ? bad_ops[$urandom_range(0, 5)]
                                       : legal_ops[$urandom_range(0, 9)];
      issue(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 16'($urandom),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    wb_mode = 0;
    wait_idle();

    // reset with both stages full and flags set
    wb_mode = 2;
    step(1);
    issue(4'd1, 1'b0, 1'b0, 4'd7, 4'd4, 16'h0, 1'b0, 4'd1, 1'b1);
    issue(4'd0, 1'b0, 1'b0, 4'd3, 4'd4, 16'h0, 1'b0, 4'd2, 1'b1);
    step(1);
    check("pre_rst_flags", 32'(flags_q), 32'(mflags));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) arch[i] = rf[i];
    mflags = 3'b000;
    wb_mode = 0;
    @(negedge clk);
    check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("post_rst_flags", 32'(flags_q), 32'd0);
    step(6);
    issue(4'd13, 1'b1, 1'b0, 4'd3, 4'd3, 16'h0, 1'b0, 4'd9, 1'b1);
    wait_idle();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
